// File: rtl/cd_mesh_pkg.sv
// rtl/cd_mesh_pkg.sv - shared sizes and port state type for the global crossbar LLC arbiter
package cd_mesh_pkg;

  localparam int CD_N_IN      = 8;
  localparam int CD_N_LLC     = 4;
  localparam int CD_SEL_W     = 3;
  // Must track the llc_proxy BURST length.
  localparam int CD_PKT_BEATS = 2;
  localparam int CD_STALL_MAX = 64;

  typedef enum logic {
    CD_IDLE = 1'b0,
    CD_LOCK = 1'b1
  } cd_port_state_e;

endpackage

// File: rtl/cd_rr_pick.sv
// rtl/cd_rr_pick.sv - combinational round-robin picker, searches upward from ptr+1 with wrap
module cd_rr_pick #(
  parameter int N     = 8,
  parameter int SEL_W = 3
) (
  input  logic [N-1:0]     req,
  input  logic [SEL_W-1:0] ptr,
  output logic             found,
  output logic [SEL_W-1:0] idx
);

  logic [SEL_W-1:0] cand;

  // Walk from the farthest offset down so the nearest requester after ptr wins.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    cand  = '0;
    for (int off = N; off >= 1; off--) begin
      cand = SEL_W'((int'(ptr) + off) % N);
      if (req[cand]) begin
        found = 1'b1;
        idx   = cand;
      end
    end
  end

endmodule

// File: rtl/cd_global_llc_arb.sv
// rtl/cd_global_llc_arb.sv - packet-level round-robin owner arbiter for the 8x4 global LLC crossbar
module cd_global_llc_arb
  import cd_mesh_pkg::*;
#(
  parameter int N_IN      = CD_N_IN,
  parameter int N_LLC     = CD_N_LLC,
  parameter int SEL_W     = CD_SEL_W,
  parameter int PKT_BEATS = CD_PKT_BEATS,
  parameter int STALL_MAX = CD_STALL_MAX
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [N_IN-1:0]        in_si,
  input  logic [N_IN*N_LLC-1:0]  in_dst,
  output logic [N_IN-1:0]        in_ri,
  output logic [N_LLC-1:0]       llc_so,
  input  logic [N_LLC-1:0]       llc_ro,
  output logic [N_LLC*SEL_W-1:0] llc_sel,
  output logic [N_LLC-1:0]       llc_lock,
  output logic [N_LLC-1:0]       stall_err
);

  localparam int BW = $clog2(PKT_BEATS + 1);
  localparam int CW = $clog2(STALL_MAX + 1);
  localparam int LW = (N_LLC > 1) ? $clog2(N_LLC) : 1;

  localparam logic [BW-1:0]    LAST_BEAT  = BW'(PKT_BEATS - 1);
  localparam logic [CW-1:0]    STALL_LAST = CW'(STALL_MAX - 1);
  localparam logic [CW-1:0]    STALL_TOP  = CW'(STALL_MAX);
  localparam logic [SEL_W-1:0] PTR_RST    = SEL_W'(N_IN - 1);

  logic [N_IN-1:0]             dst_vld;
  logic [LW-1:0]               dst_idx [N_IN];
  logic [N_LLC-1:0][N_IN-1:0]  req_all;
  logic [N_LLC-1:0][SEL_W-1:0] sel_all;
  logic [N_LLC-1:0]            xfer;

  // Destination is the lowest set mask bit; extra bits are don't-care.
  always_comb begin
    dst_vld = '0;
    for (int i = 0; i < N_IN; i++) begin
      dst_idx[i] = '0;
      for (int b = N_LLC - 1; b >= 0; b--) begin
        if (in_dst[i*N_LLC + b]) begin
          dst_vld[i] = 1'b1;
          dst_idx[i] = LW'(b);
        end
      end
    end
  end

  always_comb begin
    req_all = '0;
    for (int j = 0; j < N_LLC; j++) begin
      for (int i = 0; i < N_IN; i++) begin
        req_all[j][i] = in_si[i] & dst_vld[i] & (dst_idx[i] == LW'(j));
      end
    end
  end

  // Steer the owner's handshake; an input owns at most one port so the OR never collides.
  always_comb begin
    llc_so = '0;
    xfer   = '0;
    in_ri  = '0;
    for (int j = 0; j < N_LLC; j++) begin
      if (!reset && llc_lock[j]) begin
        llc_so[j] = in_si[sel_all[j]];
        xfer[j]   = in_si[sel_all[j]] & llc_ro[j];
        if (xfer[j]) begin
          in_ri[sel_all[j]] = 1'b1;
        end
      end
    end
  end

  for (genvar j = 0; j < N_LLC; j++) begin : g_port
    cd_port_state_e   state_q, state_d;
    logic [SEL_W-1:0] sel_q, sel_d;
    logic [SEL_W-1:0] ptr_q, ptr_d;
    logic [BW-1:0]    beat_q, beat_d;
    logic [CW-1:0]    stall_q, stall_d;
    logic             pick_found;
    logic [SEL_W-1:0] pick_idx;

    cd_rr_pick #(
      .N     (N_IN),
      .SEL_W (SEL_W)
    ) u_pick (
      .req   (req_all[j]),
      .ptr   (ptr_q),
      .found (pick_found),
      .idx   (pick_idx)
    );

    assign sel_all[j]                 = sel_q;
    assign llc_sel[j*SEL_W +: SEL_W]  = sel_q;
    assign llc_lock[j]                = (state_q == CD_LOCK);
    // Fires on the idle cycle that takes the counter to its ceiling; saturation stops repeats.
    assign stall_err[j] = !reset && (state_q == CD_LOCK) && !xfer[j] && (stall_q == STALL_LAST);

    always_comb begin
      state_d = state_q;
      sel_d   = sel_q;
      ptr_d   = ptr_q;
      beat_d  = beat_q;
      stall_d = stall_q;
      unique case (state_q)
        CD_IDLE: begin
          beat_d  = '0;
          stall_d = '0;
          if (pick_found) begin
            state_d = CD_LOCK;
            sel_d   = pick_idx;
          end
        end
        CD_LOCK: begin
          if (xfer[j]) begin
            stall_d = '0;
            if (beat_q == LAST_BEAT) begin
              state_d = CD_IDLE;
              ptr_d   = sel_q;
              beat_d  = '0;
            end else begin
              beat_d = beat_q + 1'b1;
            end
          end else if (stall_q != STALL_TOP) begin
            stall_d = stall_q + 1'b1;
          end
        end
      endcase
    end

    always_ff @(posedge clk) begin
      if (reset) begin
        state_q <= CD_IDLE;
        sel_q   <= '0;
        ptr_q   <= PTR_RST;
        beat_q  <= '0;
        stall_q <= '0;
      end else begin
        state_q <= state_d;
        sel_q   <= sel_d;
        ptr_q   <= ptr_d;
        beat_q  <= beat_d;
        stall_q <= stall_d;
      end
    end
  end

endmodule
